// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multicycle RV32I control unit.
// master = control unit (decodes IR fields, drives enables); slave = datapath side.
interface multicycle_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [1:0] Fault;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Fault
    );
    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Fault
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-style multicycle RV32I control FSM with memory-ready wait, illegal-op and timeout traps.
// Optional macro BRANCH_EXT_EN adds bne support to the BRANCH state.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_unit_if.master   bus
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                           OP_JAL  = 7'b1101111, OP_BR    = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_fault, w_fault_nxt;
    logic [1:0]      w_aluop;
    logic            w_memreq, w_pcw, w_irw, w_memw, w_regw;
    logic            w_br_ok, w_taken, w_tmo;

`ifdef BRANCH_EXT_EN
    assign w_br_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
    assign w_taken = (bus.funct3 == 3'b001) ? ~bus.Zero : bus.Zero;
`else
    assign w_br_ok = (bus.funct3 == 3'b000);
    assign w_taken = bus.Zero;
`endif

    // Only meaningful in the three states that request memory.
    assign w_tmo = TMO_EN && (r_cnt == CNT_MAX) && !bus.MemReady;

    always_comb begin
        w_next      = r_state;
        w_fault_nxt = r_fault;
        unique case (r_state)
            S_FETCH: begin
                if (bus.MemReady)  w_next = S_DECODE;
                else if (w_tmo)    begin w_next = S_TRAP; w_fault_nxt = 2'b10; end
            end
            S_DECODE: begin
                unique case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BR:             w_next = w_br_ok ? S_BRANCH : S_TRAP;
                    default:           w_next = S_TRAP;
                endcase
                if (w_next == S_TRAP) w_fault_nxt = 2'b01;
            end
            S_MEMADR:  w_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (bus.MemReady)  w_next = S_MEMWB;
                else if (w_tmo)    begin w_next = S_TRAP; w_fault_nxt = 2'b10; end
            end
            S_MEMWRITE: begin
                if (bus.MemReady)  w_next = S_FETCH;
                else if (w_tmo)    begin w_next = S_TRAP; w_fault_nxt = 2'b10; end
            end
            S_MEMWB, S_ALUWB, S_BRANCH: w_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL:    w_next = S_ALUWB;
            S_TRAP:                     w_next = S_TRAP;
            default:                    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_fault <= 2'b00;
        end else begin
            r_state <= w_next;
            r_fault <= w_fault_nxt;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_memreq && !bus.MemReady && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_memreq      = 1'b0;
        w_pcw         = 1'b0;
        w_irw         = 1'b0;
        w_memw        = 1'b0;
        w_regw        = 1'b0;
        w_aluop       = 2'b00;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        unique case (r_state)
            S_FETCH: begin
                w_memreq = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
                w_irw = bus.MemReady; w_pcw = bus.MemReady;
            end
            S_DECODE:   begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01; end
            S_MEMADR:   begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; end
            S_MEMREAD:  begin w_memreq = 1'b1; bus.AdrSrc = 1'b1; end
            S_MEMWB:    begin bus.ResultSrc = 2'b01; w_regw = 1'b1; end
            S_MEMWRITE: begin w_memreq = 1'b1; bus.AdrSrc = 1'b1; w_memw = 1'b1; end
            S_EXECR:    begin bus.ALUSrcA = 2'b10; w_aluop = 2'b10; end
            S_EXECI:    begin bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; w_aluop = 2'b10; end
            S_ALUWB:    w_regw = 1'b1;
            S_BRANCH:   begin bus.ALUSrcA = 2'b10; w_aluop = 2'b01; w_pcw = w_taken; end
            S_JAL:      begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; w_pcw = 1'b1; end
            default:    ;
        endcase
    end

    assign bus.MemReq   = w_memreq;
    // Reset masks every architectural write, even when MemReady is high in FETCH.
    assign bus.PCWrite  = w_pcw  & ~reset;
    assign bus.IRWrite  = w_irw  & ~reset;
    assign bus.MemWrite = w_memw & ~reset;
    assign bus.RegWrite = w_regw & ~reset;
    assign bus.Fault    = r_fault;

    always_comb begin
        unique case (w_aluop)
            2'b00:   bus.ALUControl = 4'b0000;
            2'b01:   bus.ALUControl = 4'b0001;
            2'b10: begin
                unique case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op == OP_R && bus.funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  bus.ALUControl = 4'b0110;
                    3'b010:  bus.ALUControl = 4'b0101;
                    3'b100:  bus.ALUControl = 4'b0100;
                    3'b101:  bus.ALUControl = bus.funct7b5 ? 4'b1000 : 4'b0111;
                    3'b110:  bus.ALUControl = 4'b0011;
                    3'b111:  bus.ALUControl = 4'b0010;
                    default: bus.ALUControl = 4'b0000;
                endcase
            end
            default: bus.ALUControl = 4'b0000;
        endcase
    end

    always_comb begin
        unique case (bus.op)
            OP_STORE: bus.ImmSrc = 2'b01;
            OP_BR:    bus.ImmSrc = 2'b10;
            OP_JAL:   bus.ImmSrc = 2'b11;
            default:  bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: random instruction stream plus directed wait, timeout, trap and reset cases.
module tb_multicycle_control_unit;
    localparam int TO = 4;

    // Instruction phases as the datapath sees them cycle by cycle.
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MB = 4, P_MW = 5,
                   P_XR = 6, P_XI = 7, P_AW = 8, P_BR = 9, P_J = 10, P_T = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if bus();
    multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    int errs = 0;
    int checks = 0;

    wire [19:0] obs = {bus.MemReq, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                       bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                       bus.ALUControl, bus.Fault};

    function automatic logic [3:0] alu_ex(logic [6:0] op, logic [2:0] f3, logic f7);
        logic [3:0] lut [8];
        lut = '{4'b0000, 4'b0110, 4'b0101, 4'b0000, 4'b0100, 4'b0111, 4'b0011, 4'b0010};
        if (f3 == 3'b000 && op == 7'b0110011 && f7) return 4'b0001;
        if (f3 == 3'b101 && f7) return 4'b1000;
        return lut[f3];
    endfunction

    function automatic logic br_ok(logic [2:0] f3);
`ifdef BRANCH_EXT_EN
        return (f3 == 3'b000) || (f3 == 3'b001);
`else
        return f3 == 3'b000;
`endif
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Expected output word for one phase, straight from the per-state output table.
    function automatic logic [19:0] expw(int ph, logic rdy, logic [6:0] op, logic [2:0] f3,
                                         logic f7, logic z, logic [1:0] flt);
        logic mr = 0, pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] rs = 0, a = 0, b = 0, f = 0;
        logic [3:0] alu = 0;
        case (ph)
            P_F:  begin mr = 1; b = 2'b10; rs = 2'b10; pcw = rdy; irw = rdy; end
            P_D:  begin a = 2'b01; b = 2'b01; end
            P_MA: begin a = 2'b10; b = 2'b01; end
            P_MR: begin mr = 1; adr = 1; end
            P_MB: begin rs = 2'b01; rw = 1; end
            P_MW: begin mr = 1; adr = 1; mw = 1; end
            P_XR: begin a = 2'b10; alu = alu_ex(op, f3, f7); end
            P_XI: begin a = 2'b10; b = 2'b01; alu = alu_ex(op, f3, f7); end
            P_AW: rw = 1;
            P_BR: begin a = 2'b10; alu = 4'b0001; pcw = (f3 == 3'b001) ? ~z : z; end
            P_J:  begin a = 2'b01; b = 2'b10; pcw = 1; end
            default: f = flt;
        endcase
        return {mr, pcw, adr, mw, irw, rw, rs, a, b, alu, f};
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(int ph, logic rdy, logic [1:0] flt, string tag);
        bus.MemReady = rdy;
        @(negedge clk);
        chk(tag, {12'd0, obs}, {12'd0, expw(ph, rdy, bus.op, bus.funct3, bus.funct7b5, bus.Zero, flt)});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.MemReady = 1'b1;
        @(negedge clk);
        chk("reset_enables", {28'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One instruction; fw/mw are MemReady-low cycles inserted in FETCH / the data-memory state.
    task automatic run(logic [6:0] op, logic [2:0] f3, logic f7, logic z, int fw, int mw);
        logic r;
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        for (int i = 0; i < fw; i++) step(P_F, 1'b0, 2'b00, "fetch_wait");
        step(P_F, 1'b1, 2'b00, "fetch");
        r = 1'($urandom);
        bus.MemReady = r;
        @(negedge clk);
        chk("immsrc", {30'd0, bus.ImmSrc}, {30'd0, imm_of(op)});
        @(posedge clk); #1;
        case (op)
            7'b0000011: begin
                step(P_MA, 1'($urandom), 2'b00, "memadr_ld");
                for (int i = 0; i < mw; i++) step(P_MR, 1'b0, 2'b00, "memread_wait");
                step(P_MR, 1'b1, 2'b00, "memread");
                step(P_MB, 1'($urandom), 2'b00, "memwb");
            end
            7'b0100011: begin
                step(P_MA, 1'($urandom), 2'b00, "memadr_st");
                for (int i = 0; i < mw; i++) step(P_MW, 1'b0, 2'b00, "memwrite_wait");
                step(P_MW, 1'b1, 2'b00, "memwrite");
            end
            7'b0110011: begin
                step(P_XR, 1'($urandom), 2'b00, "execr");
                step(P_AW, 1'($urandom), 2'b00, "aluwb_r");
            end
            7'b0010011: begin
                step(P_XI, 1'($urandom), 2'b00, "execi");
                step(P_AW, 1'($urandom), 2'b00, "aluwb_i");
            end
            7'b1101111: begin
                step(P_J, 1'($urandom), 2'b00, "jal");
                step(P_AW, 1'($urandom), 2'b00, "aluwb_j");
            end
            default: begin
                if (op == 7'b1100011 && br_ok(f3)) begin
                    step(P_BR, 1'($urandom), 2'b00, "branch");
                end else begin
                    step(P_T, 1'b1, 2'b01, "trap_illegal");
                    step(P_T, 1'b0, 2'b01, "trap_illegal_hold");
                    do_reset();
                end
            end
        endcase
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.MemReady = 1'b1;
        @(posedge clk); #1;
        do_reset();

        run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);   // lw
        run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);   // add
        run(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
        run(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);   // beq taken
        run(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);   // beq not taken
        run(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);   // bne (trap unless extension)
        run(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
        run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);   // sw, 3 wait cycles
        run(7'b0010011, 3'b101, 1'b1, 1'b0, 2, 0);   // srai with fetch wait
        run(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);   // jal
        run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);   // illegal opcode

        // Memory stuck low in FETCH: TO+1 FETCH cycles, then timeout trap.
        bus.op = 7'b0000011;
        for (int i = 0; i <= TO; i++) step(P_F, 1'b0, 2'b00, "fetch_stuck");
        step(P_T, 1'b1, 2'b10, "trap_timeout");
        step(P_T, 1'b0, 2'b10, "trap_timeout_hold");
        do_reset();
        step(P_F, 1'b1, 2'b00, "fetch_after_reset");

        // Reset during EXECI.
        bus.op = 7'b0010011; bus.funct3 = 3'b000;
        step(P_D, 1'b0, 2'b00, "decode_execi");
        reset = 1'b1;
        bus.MemReady = 1'b1;
        @(negedge clk);
        chk("execi_reset_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(P_F, 1'b1, 2'b00, "fetch_after_execi_reset");
        step(P_D, 1'b1, 2'b00, "decode_again");
        step(P_XI, 1'b1, 2'b00, "execi_again");
        step(P_AW, 1'b1, 2'b00, "aluwb_again");

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom);
            if (f3 == 3'b011) f3 = 3'b111;
            run(ops[$urandom_range(0, 5)], f3, 1'($urandom), 1'($urandom),
                $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
